reg_write_ctrl: RTL and testbench
=================================

Name: reg_write_ctrl

Overview:
- Owns the single write port (WRITE/INADDRESS/IN) of the 8x8 register file and shares it between two requesters: ALU writeback and data-memory load return.
- After reset it runs a hardware clear sweep that zeroes R0..R7 through the write port, then arbitrates.
- Arbitration is memory-priority with an anti-starvation limit. Losing ALU writes are held in a small FIFO.
- A forwarding lookup exposes pending (not yet committed) write data to the datapath.

Parameters:
- DEPTH, 2, ALU pending-FIFO entries (power of two, 2..4)
- STARVE_LIMIT, 3, consecutive MEM grants allowed while the ALU side waits (>=1)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- ALU_VALID  in  1  ALU writeback request
- ALU_ADDR  in  3  ALU destination register
- ALU_DATA  in  8  ALU result
- ALU_READY  out  1  ALU write accepted when VALID&&READY
- MEM_VALID  in  1  load-return request
- MEM_ADDR  in  3  load destination register
- MEM_DATA  in  8  load data
- MEM_READY  out  1  load write accepted when VALID&&READY
- WRITE  out  1  register-file write enable (registered)
- INADDRESS  out  3  register-file write address (registered)
- IN  out  8  register-file write data (registered)
- CLEAR_BUSY  out  1  clear sweep in progress
- QADDR  in  3  forwarding query address
- QHIT  out  1  a pending or in-flight write targets QADDR
- QDATA  out  8  youngest pending data for QADDR; 0 when !QHIT

Behaviour:
- Reset (RESET=0, async): WRITE=0, INADDRESS=0, IN=0, FIFO emptied, starve count=0, clear counter=0, state=CLEAR. CLEAR_BUSY=1, ALU_READY=0, MEM_READY=0.
- States: CLEAR -> RUN. RUN is held until the next reset.
- CLEAR: lasts 8 cycles. Each cycle issues a write of 0 to the address given by the counter (0..7). Transition to RUN when the counter reaches 7.
  - CLEAR_BUSY = (state==CLEAR).
  - Registered outputs therefore show WRITE=1, INADDRESS=0..7, IN=0 on cycles 1..8 after reset release.
- Write latency: a write granted in cycle N appears on WRITE/INADDRESS/IN in cycle N+1. At most one write per cycle. WRITE=0 in any cycle with no grant.
- ALU side (RUN only):
  - ALU_READY = FIFO count < DEPTH.
  - An accepted ALU write is pushed to the FIFO.
  - If the FIFO is empty and the ALU side is granted in the same cycle, the accepted write bypasses the FIFO and goes straight to the port.
- ALU side "waiting" = FIFO non-empty, or ALU_VALID && ALU_READY.
- Grant rule (RUN), evaluated each cycle:
  - MEM wins when MEM_VALID, no FIFO entry matches MEM_ADDR, and NOT (ALU waiting && starve==STARVE_LIMIT).
  - Otherwise, if the ALU side is waiting, grant the FIFO head, or the direct ALU write when the FIFO is empty.
  - MEM_READY = MEM grant (combinational).
- Starve counter:
  - Increments on a MEM grant while the ALU side is waiting.
  - Clears on any ALU-side grant.
  - Saturates at STARVE_LIMIT.
- Ordering: a load is younger than every queued ALU write. On a MEM_ADDR match against the FIFO, MEM stalls until the matching entries drain, so the load data is the final value.
- Forwarding (combinational). Search order, youngest first:
  1. The accepted-this-cycle ALU write
  2. FIFO entries, tail to head
  3. The currently driven WRITE/INADDRESS/IN
  - Return the first address match. MEM data is not forwarded.
- Simultaneous push and pop on a full FIFO is not allowed: ALU_READY=0 when full, regardless of pop.
- Reset mid-operation drops all queued writes silently and restarts the sweep from address 0.

Decomposition:
- Package reg_ctrl_pkg holds:
  - constants: NUM_REGS=8, ADDR_W=3, DATA_W=8
  - state enum: CLEAR, RUN
  - struct: wb_entry_t {addr, data}
- Sub-module alu_wb_fifo: DEPTH-entry synchronous FIFO with push/pop, count, and a per-entry address-match vector plus youngest-match data, used by both the conflict check and forwarding.

Test Plan:
- Release RESET at t0 -> WRITE=1 for exactly 8 cycles with INADDRESS 0,1,...,7 and IN=0; CLEAR_BUSY=1 through the sweep, then 0; both READYs low during CLEAR.
- RUN, ALU_VALID addr=3 data=0x2A alone -> ALU_READY=1; next cycle WRITE=1, INADDRESS=3, IN=0x2A; FIFO stays empty.
- STARVE_LIMIT=3, continuous MEM_VALID (addrs 1,2,4,6) with ALU r0=0x05 queued -> MEM granted 3 cycles, 4th cycle MEM_READY=0 and port writes r0=0x05, then MEM resumes.
- Continuous MEM stream plus ALU pushes r1=0x10 and r2=0x20 -> FIFO full; ALU_READY=0 in the third cycle; QADDR=2 gives QHIT=1, QDATA=0x20.
- FIFO holds r5=0x11, MEM_VALID r5=0x77 -> MEM_READY=0 until the r5=0x11 write issues; next write r5=0x77; final r5 contents 0x77.
- RESET low mid-stream with 2 FIFO entries -> WRITE=0 immediately (async), FIFO count 0, QHIT=0; after release the sweep restarts at INADDRESS=0.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
//   NUM_REGS/ADDR_W/DATA_W : register file geometry
//   state_t                : controller phase (clear sweep, then arbitration)
//   wb_entry_t             : one pending register write {addr, data}
package reg_ctrl_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// Pending-ALU-write FIFO with address lookups.
//   i_clk, i_rst_n   : clock, async active-low reset (empties the FIFO)
//   i_push/i_push_entry, i_pop : enqueue at tail / dequeue head (caller never pushes when full)
//   i_mem_addr       : address compared against every valid entry -> o_mem_match (per physical entry)
//   i_q_addr         : forwarding address -> o_q_hit/o_q_data (youngest matching entry)
//   o_head, o_count  : oldest entry and occupancy
module alu_wb_fifo
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  wb_entry_t                   i_push_entry,
  input  logic                        i_pop,
  input  logic [ADDR_W-1:0]           i_mem_addr,
  input  logic [ADDR_W-1:0]           i_q_addr,
  output wb_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]  o_count,
  output logic [DEPTH-1:0]            o_mem_match,
  output logic                        o_q_hit,
  output logic [DATA_W-1:0]           o_q_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage needs no reset: entries are qualified by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk head->tail so a later (younger) match overrides an older one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = '0;
    o_mem_match = '0;
    o_q_hit     = 1'b0;
    o_q_data    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = r_rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        if (r_mem[idx].addr == i_mem_addr) o_mem_match[idx] = 1'b1;
        if (r_mem[idx].addr == i_q_addr) begin
          o_q_hit  = 1'b1;
          o_q_data = r_mem[idx].data;
        end
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/reg_write_ctrl.sv
// Owner of the register-file write port, shared by ALU writeback and load return.
//   CLK, RESET (async, active-low)
//   ALU_VALID/ALU_ADDR/ALU_DATA -> ALU_READY : ALU writeback handshake (queued when it loses)
//   MEM_VALID/MEM_ADDR/MEM_DATA -> MEM_READY : load-return handshake (READY == grant)
//   WRITE/INADDRESS/IN : registered register-file write port
//   CLEAR_BUSY         : post-reset zeroing sweep in progress
//   QADDR -> QHIT/QDATA: forwarding lookup over not-yet-committed writes
module reg_write_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_ADDR,
  input  logic [DATA_W-1:0] ALU_DATA,
  output logic              ALU_READY,
  input  logic              MEM_VALID,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_READY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic              CLEAR_BUSY,
  input  logic [ADDR_W-1:0] QADDR,
  output logic              QHIT,
  output logic [DATA_W-1:0] QDATA
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [STV_W-1:0]  r_starve;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_clr_nxt;
  logic [STV_W-1:0]  w_starve_nxt;
  logic              w_wr_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  logic              w_alu_ready;
  logic              w_alu_acc;
  logic              w_alu_wait;
  logic              w_mem_grant;
  logic              w_push;
  logic              w_pop;

  wb_entry_t         w_alu_entry;
  wb_entry_t         w_head;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [DEPTH-1:0]  w_mem_match;
  logic              w_fifo_q_hit;
  logic [DATA_W-1:0] w_fifo_q_data;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_mem_conflict;

  assign w_alu_entry.addr = ALU_ADDR;
  assign w_alu_entry.data = ALU_DATA;

  alu_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk        (CLK),
    .i_rst_n      (RESET),
    .i_push       (w_push),
    .i_push_entry (w_alu_entry),
    .i_pop        (w_pop),
    .i_mem_addr   (MEM_ADDR),
    .i_q_addr     (QADDR),
    .o_head       (w_head),
    .o_count      (w_fifo_cnt),
    .o_mem_match  (w_mem_match),
    .o_q_hit      (w_fifo_q_hit),
    .o_q_data     (w_fifo_q_data)
  );

  assign w_fifo_empty   = (w_fifo_cnt == '0);
  assign w_fifo_full    = (w_fifo_cnt == CNT_W'(DEPTH));
  // A load must not overtake an older queued ALU write to the same register.
  assign w_mem_conflict = |w_mem_match;

  // State, sweep counter, starvation counter and the registered write port.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_starve  <= '0;
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_nxt;
      r_starve  <= w_starve_nxt;
      WRITE     <= w_wr_nxt;
      INADDRESS <= w_addr_nxt;
      IN        <= w_data_nxt;
    end
  end

  // Next state, arbitration and next write-port value.
  always_comb begin
    w_state_nxt  = r_state;
    w_clr_nxt    = r_clr_cnt;
    w_starve_nxt = r_starve;
    w_wr_nxt     = 1'b0;
    w_addr_nxt   = '0;
    w_data_nxt   = '0;
    w_alu_ready  = 1'b0;
    w_alu_acc    = 1'b0;
    w_alu_wait   = 1'b0;
    w_mem_grant  = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      CLEAR: begin
        w_wr_nxt   = 1'b1;
        w_addr_nxt = r_clr_cnt;
        w_clr_nxt  = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == ADDR_W'(NUM_REGS - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        w_alu_ready = !w_fifo_full;
        w_alu_acc   = ALU_VALID && w_alu_ready;
        w_alu_wait  = !w_fifo_empty || w_alu_acc;
        w_mem_grant = MEM_VALID && !w_mem_conflict &&
                      !(w_alu_wait && (r_starve == STV_W'(STARVE_LIMIT)));
        if (w_mem_grant) begin
          w_wr_nxt   = 1'b1;
          w_addr_nxt = MEM_ADDR;
          w_data_nxt = MEM_DATA;
          w_push     = w_alu_acc;
          if (w_alu_wait && (r_starve < STV_W'(STARVE_LIMIT)))
            w_starve_nxt = r_starve + STV_W'(1);
        end else if (w_alu_wait) begin
          w_wr_nxt     = 1'b1;
          w_starve_nxt = '0;
          if (w_fifo_empty) begin
            // Bypass: accepted write goes straight to the port.
            w_addr_nxt = ALU_ADDR;
            w_data_nxt = ALU_DATA;
          end else begin
            w_pop      = 1'b1;
            w_addr_nxt = w_head.addr;
            w_data_nxt = w_head.data;
            w_push     = w_alu_acc;
          end
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign ALU_READY  = w_alu_ready;
  assign MEM_READY  = w_mem_grant;
  assign CLEAR_BUSY = (r_state == CLEAR);

  // Forwarding, youngest first: this cycle's ALU accept, queued entries, port in flight.
  always_comb begin
    QHIT  = 1'b0;
    QDATA = '0;
    if (w_alu_acc && (ALU_ADDR == QADDR)) begin
      QHIT  = 1'b1;
      QDATA = ALU_DATA;
    end else if (w_fifo_q_hit) begin
      QHIT  = 1'b1;
      QDATA = w_fifo_q_data;
    end else if (WRITE && (INADDRESS == QADDR)) begin
      QHIT  = 1'b1;
      QDATA = IN;
    end
  end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: request queues drive the handshakes, a queue-based
// model predicts the port writes (scoreboard) and the combinational outputs.
module tb_reg_write_ctrl;
  import reg_ctrl_pkg::*;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 3;

  typedef struct packed {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
  } port_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ALU_VALID = 1'b0;
  logic [2:0] ALU_ADDR = '0;
  logic [7:0] ALU_DATA = '0;
  logic       ALU_READY;
  logic       MEM_VALID = 1'b0;
  logic [2:0] MEM_ADDR = '0;
  logic [7:0] MEM_DATA = '0;
  logic       MEM_READY;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic       CLEAR_BUSY;
  logic [2:0] QADDR = '0;
  logic       QHIT;
  logic [7:0] QDATA;

  reg_write_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .CLEAR_BUSY(CLEAR_BUSY),
    .QADDR(QADDR), .QHIT(QHIT), .QDATA(QDATA)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  port_t     exp_q[$];
  wb_entry_t alu_req_q[$];
  wb_entry_t mem_req_q[$];
  wb_entry_t m_fifo[$];
  bit        m_clearing;
  int        m_clr;
  int        m_starve;
  port_t     m_port;
  bit        alu_gate = 1'b1;
  bit        mem_gate = 1'b1;
  logic [2:0] qaddr_sel = '0;
  logic [7:0] rf_dut [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_init();
    m_fifo.delete();
    m_clearing = 1'b1;
    m_clr      = 0;
    m_starve   = 0;
    m_port     = '0;
  endtask

  // Scoreboard monitor: every cycle the port must match the oldest prediction (idle if none).
  initial begin
    port_t e;
    for (int i = 0; i < 8; i++) rf_dut[i] = 8'hFF;
    forever begin
      @(posedge CLK); #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : port_t'(0);
      chk("port_write", 32'(WRITE), 32'(e.w));
      if (e.w) begin
        chk("port_addr", 32'(INADDRESS), 32'(e.a));
        chk("port_data", 32'(IN), 32'(e.d));
      end
      if (WRITE === 1'b1) rf_dut[INADDRESS] = IN;
    end
  end

  // One clock: drive request fronts, check combinational outputs, predict next port value.
  task automatic cycle(input bit rel = 1'b0);
    bit        av, mv, acc, wt, conf, mg, hit;
    wb_entry_t a, m;
    port_t     nxt;
    logic [7:0] qd;
    int        fsz;
    @(posedge CLK); #1;
    if (rel) RESET = 1'b1;
    av = alu_gate && (alu_req_q.size() > 0);
    mv = mem_gate && (mem_req_q.size() > 0);
    a  = av ? alu_req_q[0] : wb_entry_t'($urandom);
    m  = mv ? mem_req_q[0] : wb_entry_t'($urandom);
    ALU_VALID = av; ALU_ADDR = a.addr; ALU_DATA = a.data;
    MEM_VALID = mv; MEM_ADDR = m.addr; MEM_DATA = m.data;
    QADDR = qaddr_sel;
    #1;
    fsz = m_fifo.size();
    acc = !m_clearing && av && (fsz < DEPTH);
    wt  = (fsz > 0) || acc;
    // Youngest pending write to QADDR.
    hit = 1'b0; qd = '0;
    if (acc && a.addr == qaddr_sel) begin hit = 1'b1; qd = a.data; end
    for (int i = fsz - 1; i >= 0; i--)
      if (!hit && m_fifo[i].addr == qaddr_sel) begin hit = 1'b1; qd = m_fifo[i].data; end
    if (!hit && m_port.w && m_port.a == qaddr_sel) begin hit = 1'b1; qd = m_port.d; end
    chk("qhit", 32'(QHIT), 32'(hit));
    chk("qdata", 32'(QDATA), 32'(qd));
    nxt = '0;
    if (m_clearing) begin
      chk("clear_busy", 32'(CLEAR_BUSY), 1);
      chk("alu_ready_clr", 32'(ALU_READY), 0);
      chk("mem_ready_clr", 32'(MEM_READY), 0);
      nxt = '{w: 1'b1, a: 3'(m_clr), d: 8'h00};
      m_clr++;
      if (m_clr == 8) m_clearing = 1'b0;
    end else begin
      conf = 1'b0;
      foreach (m_fifo[i]) if (m_fifo[i].addr == m.addr) conf = 1'b1;
      mg = mv && !conf && !(wt && m_starve == STARVE_LIMIT);
      chk("clear_busy", 32'(CLEAR_BUSY), 0);
      chk("alu_ready", 32'(ALU_READY), 32'(fsz < DEPTH));
      chk("mem_ready", 32'(MEM_READY), 32'(mg));
      if (mg) begin
        nxt = '{w: 1'b1, a: m.addr, d: m.data};
        void'(mem_req_q.pop_front());
        if (wt && m_starve < STARVE_LIMIT) m_starve++;
        if (acc) m_fifo.push_back(a);
      end else if (wt) begin
        m_starve = 0;
        if (fsz > 0) begin
          nxt = '{w: 1'b1, a: m_fifo[0].addr, d: m_fifo[0].data};
          void'(m_fifo.pop_front());
          if (acc) m_fifo.push_back(a);
        end else begin
          nxt = '{w: 1'b1, a: a.addr, d: a.data};
        end
      end
      if (acc) void'(alu_req_q.pop_front());
    end
    exp_q.push_back(nxt);
    m_port = nxt;
  endtask

  task automatic do_reset();
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    chk("rst_write", 32'(WRITE), 0);
    chk("rst_qhit", 32'(QHIT), 0);
    chk("rst_alu_ready", 32'(ALU_READY), 0);
    chk("rst_mem_ready", 32'(MEM_READY), 0);
    chk("rst_clear_busy", 32'(CLEAR_BUSY), 1);
    exp_q.delete(); alu_req_q.delete(); mem_req_q.delete();
    model_init();
    ALU_VALID = 1'b0; MEM_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    cycle(1'b1);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((alu_req_q.size() > 0 || mem_req_q.size() > 0 || m_fifo.size() > 0) && n < max_cycles) begin
      cycle(); n++;
    end
    chk("drain_timeout", 32'(n < max_cycles), 1);
    repeat (2) cycle();
  endtask

  function automatic wb_entry_t ent(input int ad, input int da);
    wb_entry_t e;
    e.addr = 3'(ad);
    e.data = 8'(da);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_init();
    repeat (3) @(posedge CLK);
    #2;
    chk("reset_write", 32'(WRITE), 0);
    chk("reset_clear_busy", 32'(CLEAR_BUSY), 1);
    chk("reset_alu_ready", 32'(ALU_READY), 0);
    chk("reset_mem_ready", 32'(MEM_READY), 0);

    // Clear sweep.
    cycle(1'b1);
    repeat (9) cycle();
    for (int i = 0; i < 8; i++) chk("sweep_zero", 32'(rf_dut[i]), 0);

    // Lone ALU write bypasses the FIFO.
    qaddr_sel = 3'd3;
    alu_req_q.push_back(ent(3, 8'h2A));
    drain(20);
    chk("r3_value", 32'(rf_dut[3]), 32'h2A);

    // Starvation limit against a continuous load stream.
    qaddr_sel = 3'd0;
    alu_req_q.push_back(ent(0, 8'h05));
    mem_req_q.push_back(ent(1, 8'hA1)); mem_req_q.push_back(ent(2, 8'hA2));
    mem_req_q.push_back(ent(4, 8'hA4)); mem_req_q.push_back(ent(6, 8'hA6));
    drain(20);
    chk("r0_value", 32'(rf_dut[0]), 32'h05);
    chk("r6_value", 32'(rf_dut[6]), 32'hA6);

    // FIFO fills while loads win; forwarding of queued r2.
    qaddr_sel = 3'd2;
    alu_req_q.push_back(ent(1, 8'h10)); alu_req_q.push_back(ent(2, 8'h20));
    mem_req_q.push_back(ent(3, 8'hB3)); mem_req_q.push_back(ent(4, 8'hB4));
    mem_req_q.push_back(ent(5, 8'hB5)); mem_req_q.push_back(ent(6, 8'hB6));
    drain(20);
    chk("r2_value", 32'(rf_dut[2]), 32'h20);

    // Load to a register with a queued ALU write must land last.
    qaddr_sel = 3'd5;
    alu_req_q.push_back(ent(5, 8'h11));
    mem_req_q.push_back(ent(7, 8'h33)); mem_req_q.push_back(ent(5, 8'h77));
    drain(20);
    chk("r5_final", 32'(rf_dut[5]), 32'h77);

    // Reset with queued writes pending.
    qaddr_sel = 3'd2;
    for (int i = 0; i < 4; i++) mem_req_q.push_back(ent(1, 8'hC0 + i));
    alu_req_q.push_back(ent(2, 8'hD2)); alu_req_q.push_back(ent(3, 8'hD3));
    repeat (2) cycle();
    do_reset();
    repeat (9) cycle();
    for (int i = 0; i < 8; i++) chk("resweep_zero", 32'(rf_dut[i]), 0);

    // Randomized traffic with a mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      if ($urandom_range(0, 3) != 0 && alu_req_q.size() < 4)
        alu_req_q.push_back(ent($urandom_range(0, 3), $urandom_range(0, 255)));
      if ($urandom_range(0, 2) != 0 && mem_req_q.size() < 4)
        mem_req_q.push_back(ent($urandom_range(0, 3), $urandom_range(0, 255)));
      alu_gate  = ($urandom_range(0, 4) != 0);
      mem_gate  = ($urandom_range(0, 4) != 0);
      qaddr_sel = 3'($urandom_range(0, 7));
      cycle();
    end
    alu_gate = 1'b1; mem_gate = 1'b1;
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
